scarv_mem_arbiter: RTL and testbench
====================================

Name: scarv_mem_arbiter

Overview:
Two-port memory arbiter that lets the PicoRV32 core and the XCrypto co-processor share one memory port in PicoRV32-native (valid/ready) style. It sits between the CPU's native memory interface, the COP's SRAM-style enable/stall interface, and a single downstream native port. That downstream port feeds one AXI4-lite adapter instead of two. Arbitration is round-robin or fixed priority, with one outstanding transaction and a per-transaction response timeout.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between PRV and COP; 1 = COP always wins a tie.
TIMEOUT, 255, cycles to wait for mem_ready before aborting with an error; 0 = timeout disabled.
TIMEOUT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TIMEOUT_W.

Ports:
g_clk  in  1  clock; all state updates on the rising edge.
g_resetn  in  1  reset, asynchronous, active-low.
prv_mem_valid  in  1  CPU request; held until prv_mem_ready.
prv_mem_instr  in  1  CPU instruction-fetch flag.
prv_mem_addr  in  32  CPU address.
prv_mem_wdata  in  32  CPU write data.
prv_mem_wstrb  in  4  CPU byte strobes; 0 = read.
prv_mem_ready  out  1  CPU transaction complete, one-cycle pulse.
prv_mem_rdata  out  32  CPU read data, valid with prv_mem_ready.
prv_bus_error  out  1  pulse with prv_mem_ready when the CPU transaction timed out.
cop_mem_cen  in  1  COP request; held while cop_mem_stall is high.
cop_mem_wen  in  1  COP write enable.
cop_mem_addr  in  32  COP address.
cop_mem_wdata  in  32  COP write data.
cop_mem_ben  in  4  COP byte enables.
cop_mem_rdata  out  32  COP read data, valid when cen=1 and stall=0.
cop_mem_stall  out  1  COP stall.
cop_mem_error  out  1  COP error, one-cycle pulse with stall=0.
mem_valid  out  1  downstream request.
mem_instr  out  1  downstream instruction flag.
mem_addr  out  32  downstream address.
mem_wdata  out  32  downstream write data.
mem_wstrb  out  4  downstream strobes.
mem_ready  in  1  downstream complete.
mem_rdata  in  32  downstream read data.

Behaviour:
- State machine (IDLE, GNT_PRV, GNT_COP). Registers: state, last_grant, payload (instr/addr/wdata/wstrb), tcnt.
- Reset values (asynchronous, taking effect immediately on g_resetn low):
  - state = IDLE, last_grant = COP, tcnt = 0, payload = 0.
  - All outputs 0, except the rdata outputs, which are combinational pass-through of mem_rdata.
- IDLE → grant selection:
  - Only prv_mem_valid: go to GNT_PRV.
  - Only cop_mem_cen: go to GNT_COP.
  - Both requesting, FIXED_PRIO=0: grant the port that is not last_grant.
  - Both requesting, FIXED_PRIO=1: grant COP.
  - Payload of the granted port is captured on the same edge.
  - COP capture: wstrb = cop_mem_wen ? cop_mem_ben : 4'h0; instr = 0.
- Downstream signalling:
  - mem_valid = 1 exactly while state is GNT_PRV or GNT_COP.
  - mem_addr, mem_wdata, mem_wstrb and mem_instr come from the payload registers and are stable for the whole grant.
  - Request-to-mem_valid latency is 1 cycle.
- Completion (GNT_x with mem_ready=1):
  - Granted side completes combinationally in that cycle: prv_mem_ready=1, or cop_mem_stall=0.
  - Next state IDLE; last_grant updated to the granted side; tcnt cleared.
  - Earliest next grant is 2 cycles after completion (IDLE, then GNT).
- COP stall rule: cop_mem_stall = cop_mem_cen & ~(state==GNT_COP & (mem_ready | timeout_hit)).
  - So stall stays high while the COP waits in IDLE or while the CPU holds the grant.
  - stall = 0 whenever cen = 0.
- Timeout (TIMEOUT != 0):
  - tcnt increments each GNT cycle with mem_ready=0.
  - timeout_hit = (tcnt == TIMEOUT-1) & ~mem_ready.
  - On timeout_hit, the granted side completes with an error:
    - CPU: prv_mem_ready=1, prv_bus_error=1, prv_mem_rdata forced to 0.
    - COP: stall=0, cop_mem_error=1.
  - mem_valid then drops (downstream transaction abandoned) and state returns to IDLE.
  - mem_ready on the same cycle as timeout_hit counts as normal completion; there is no error.
- A requester dropping its request mid-grant is illegal; the arbiter keeps the grant until mem_ready or timeout.
- Outputs of the side not granted: ready/error = 0. The rdata outputs are don't-care but pass through mem_rdata.
- Reset mid-transaction: state returns to IDLE immediately and any in-flight transaction is discarded. Round-robin restarts with PRV preferred.

Test Plan:
- PRV read alone: prv_mem_valid, addr 0xC000_0000; mem_ready on the 3rd GNT cycle with rdata 0xDEADBEEF → mem_valid rises 1 cycle after request; prv_mem_ready pulses 1 cycle with rdata 0xDEADBEEF; mem_wstrb = 0.
- Simultaneous first requests after reset (PRV addr 0x100, COP addr 0x200): PRV is granted first (mem_addr 0x100), then COP (0x200). cop_mem_stall stays high until COP completes. A repeated tie then alternates COP, PRV.
- COP write cen=1, wen=1, ben=0x3, wdata 0x1234_5678 → mem_wstrb=0x3, mem_wdata=0x1234_5678. COP read with wen=0, ben=0xF → mem_wstrb=0x0.
- Timeout, TIMEOUT=255, COP request with mem_ready held low → at GNT cycle 255, cop_mem_error=1 and stall=0 for one cycle; mem_valid=0 next cycle. Repeat for PRV → prv_bus_error=1, prv_mem_rdata=0.
- g_resetn pulled low asynchronously mid GNT_COP → mem_valid, stall and all ready/error outputs drop before the next edge. After release, with both requesting, PRV is granted.
- FIXED_PRIO=1, COP re-requests immediately after each completion while PRV is held valid → COP granted every time; PRV granted only in an IDLE cycle where cen=0.

Source files
------------

// File: rtl/scarv_mem_arbiter.sv
// rtl/scarv_mem_arbiter.sv - shares one native memory port between the PicoRV32 core and the XCrypto COP
// One transaction in flight; each grant is abandoned with an error if mem_ready never arrives.
module scarv_mem_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255,
  parameter int TIMEOUT_W  = 8
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        prv_mem_valid,
  input  logic        prv_mem_instr,
  input  logic [31:0] prv_mem_addr,
  input  logic [31:0] prv_mem_wdata,
  input  logic [3:0]  prv_mem_wstrb,
  output logic        prv_mem_ready,
  output logic [31:0] prv_mem_rdata,
  output logic        prv_bus_error,
  input  logic        cop_mem_cen,
  input  logic        cop_mem_wen,
  input  logic [31:0] cop_mem_addr,
  input  logic [31:0] cop_mem_wdata,
  input  logic [3:0]  cop_mem_ben,
  output logic [31:0] cop_mem_rdata,
  output logic        cop_mem_stall,
  output logic        cop_mem_error,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_PRV = 2'd1,
    GNT_COP = 2'd2
  } state_e;

  localparam int TLIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TIMEOUT_W-1:0] TLIM = TLIM_I[TIMEOUT_W-1:0];

  state_e                state_q, state_d;
  logic                  last_cop_q, last_cop_d;
  logic                  instr_q, instr_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0]  tcnt_q, tcnt_d;

  logic granted;
  logic timeout_hit;
  logic done;
  logic pick_cop;

  assign granted     = (state_q != IDLE);
  // mem_ready on the last allowed cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && granted && (tcnt_q == TLIM) && !mem_ready;
  assign done        = granted && (mem_ready || timeout_hit);

  always_comb begin
    pick_cop = cop_mem_cen;
    if (prv_mem_valid && cop_mem_cen) begin
      pick_cop = (FIXED_PRIO != 0) ? 1'b1 : !last_cop_q;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      last_cop_q <= 1'b1;
      instr_q    <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      tcnt_q     <= '0;
    end else begin
      last_cop_q <= last_cop_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      tcnt_q     <= tcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_cop_d = last_cop_q;
    instr_d    = instr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      IDLE: begin
        if (prv_mem_valid || cop_mem_cen) begin
          tcnt_d = '0;
          if (pick_cop) begin
            state_d = GNT_COP;
            instr_d = 1'b0;
            addr_d  = cop_mem_addr;
            wdata_d = cop_mem_wdata;
            wstrb_d = cop_mem_wen ? cop_mem_ben : 4'h0;
          end else begin
            state_d = GNT_PRV;
            instr_d = prv_mem_instr;
            addr_d  = prv_mem_addr;
            wdata_d = prv_mem_wdata;
            wstrb_d = prv_mem_wstrb;
          end
        end
      end
      GNT_PRV, GNT_COP: begin
        if (done) begin
          state_d    = IDLE;
          last_cop_d = (state_q == GNT_COP);
          tcnt_d     = '0;
        end else if (TIMEOUT != 0) begin
          tcnt_d = tcnt_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic prv_err;
    prv_err       = (state_q == GNT_PRV) && timeout_hit;
    mem_valid     = granted;
    mem_instr     = instr_q;
    mem_addr      = addr_q;
    mem_wdata     = wdata_q;
    mem_wstrb     = wstrb_q;
    prv_mem_ready = (state_q == GNT_PRV) && done;
    prv_bus_error = prv_err;
    prv_mem_rdata = prv_err ? 32'h0 : mem_rdata;
    cop_mem_rdata = mem_rdata;
    // Gated by reset so the COP sees no stall while the arbiter is held in reset.
    cop_mem_stall = g_resetn && cop_mem_cen && !((state_q == GNT_COP) && done);
    cop_mem_error = (state_q == GNT_COP) && timeout_hit;
  end

endmodule

// File: tb/tb_scarv_mem_arbiter.sv
// tb/tb_scarv_mem_arbiter.sv - self-checking bench for scarv_mem_arbiter (round-robin and fixed-priority instances)
module tb_scarv_mem_arbiter;

  localparam int TO = 255;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        prv_mem_valid, prv_mem_instr;
  logic [31:0] prv_mem_addr, prv_mem_wdata;
  logic [3:0]  prv_mem_wstrb;
  logic        cop_mem_cen, cop_mem_wen;
  logic [31:0] cop_mem_addr, cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        o_prv_ready[2];
  logic [31:0] o_prv_rdata[2];
  logic        o_prv_err[2];
  logic [31:0] o_cop_rdata[2];
  logic        o_stall[2];
  logic        o_cop_err[2];
  logic        o_valid[2];
  logic        o_instr[2];
  logic [31:0] o_addr[2];
  logic [31:0] o_wdata[2];
  logic [3:0]  o_wstrb[2];

  always #5 g_clk = ~g_clk;

  scarv_mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(TO), .TIMEOUT_W(8)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .prv_mem_valid(prv_mem_valid), .prv_mem_instr(prv_mem_instr), .prv_mem_addr(prv_mem_addr),
    .prv_mem_wdata(prv_mem_wdata), .prv_mem_wstrb(prv_mem_wstrb), .prv_mem_ready(o_prv_ready[0]),
    .prv_mem_rdata(o_prv_rdata[0]), .prv_bus_error(o_prv_err[0]),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(o_cop_rdata[0]),
    .cop_mem_stall(o_stall[0]), .cop_mem_error(o_cop_err[0]),
    .mem_valid(o_valid[0]), .mem_instr(o_instr[0]), .mem_addr(o_addr[0]), .mem_wdata(o_wdata[0]),
    .mem_wstrb(o_wstrb[0]), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  scarv_mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(TO), .TIMEOUT_W(8)) dut_fp (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .prv_mem_valid(prv_mem_valid), .prv_mem_instr(prv_mem_instr), .prv_mem_addr(prv_mem_addr),
    .prv_mem_wdata(prv_mem_wdata), .prv_mem_wstrb(prv_mem_wstrb), .prv_mem_ready(o_prv_ready[1]),
    .prv_mem_rdata(o_prv_rdata[1]), .prv_bus_error(o_prv_err[1]),
    .cop_mem_cen(cop_mem_cen), .cop_mem_wen(cop_mem_wen), .cop_mem_addr(cop_mem_addr),
    .cop_mem_wdata(cop_mem_wdata), .cop_mem_ben(cop_mem_ben), .cop_mem_rdata(o_cop_rdata[1]),
    .cop_mem_stall(o_stall[1]), .cop_mem_error(o_cop_err[1]),
    .mem_valid(o_valid[1]), .mem_instr(o_instr[1]), .mem_addr(o_addr[1]), .mem_wdata(o_wdata[1]),
    .mem_wstrb(o_wstrb[1]), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Model per instance: owner 0=none 1=PRV 2=COP, waited = GNT cycles already spent.
  int          own[2], lst[2], wt[2];
  logic [31:0] m_addr[2], m_wdata[2];
  logic [3:0]  m_wstrb[2];
  logic        m_instr[2];

  int checks = 0;
  int errors = 0;
  bit prv_done_seen, cop_done_seen;

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own[d] = 0; lst[d] = 2; wt[d] = 0;
      m_addr[d] = '0; m_wdata[d] = '0; m_wstrb[d] = '0; m_instr[d] = 1'b0;
    end
  endtask

  task automatic step();
    bit v, hit, dn[2];
    int p;
    #1;
    for (int d = 0; d < 2; d++) begin
      v     = (own[d] != 0);
      hit   = v && !mem_ready && (wt[d] == TO - 1);
      dn[d] = v && (mem_ready || hit);
      chk(d, "mem_valid", o_valid[d], v);
      if (v) begin
        chk(d, "mem_addr", o_addr[d], m_addr[d]);
        chk(d, "mem_wdata", o_wdata[d], m_wdata[d]);
        chk(d, "mem_wstrb", o_wstrb[d], m_wstrb[d]);
        chk(d, "mem_instr", o_instr[d], m_instr[d]);
      end
      chk(d, "prv_ready", o_prv_ready[d], own[d] == 1 && dn[d]);
      chk(d, "prv_err", o_prv_err[d], own[d] == 1 && hit);
      chk(d, "prv_rdata", o_prv_rdata[d], (own[d] == 1 && hit) ? 32'h0 : mem_rdata);
      chk(d, "cop_rdata", o_cop_rdata[d], mem_rdata);
      chk(d, "cop_stall", o_stall[d], cop_mem_cen && !(own[d] == 2 && dn[d]));
      chk(d, "cop_err", o_cop_err[d], own[d] == 2 && hit);
    end
    prv_done_seen = o_prv_ready[0];
    cop_done_seen = cop_mem_cen && !o_stall[0];
    @(posedge g_clk);
    for (int d = 0; d < 2; d++) begin
      if (own[d] != 0) begin
        if (dn[d]) begin lst[d] = own[d]; own[d] = 0; wt[d] = 0; end
        else wt[d]++;
      end else if (prv_mem_valid || cop_mem_cen) begin
        if (prv_mem_valid && cop_mem_cen) p = (d == 1) ? 2 : ((lst[d] == 1) ? 2 : 1);
        else p = prv_mem_valid ? 1 : 2;
        own[d] = p; wt[d] = 0;
        if (p == 1) begin
          m_addr[d] = prv_mem_addr; m_wdata[d] = prv_mem_wdata;
          m_wstrb[d] = prv_mem_wstrb; m_instr[d] = prv_mem_instr;
        end else begin
          m_addr[d] = cop_mem_addr; m_wdata[d] = cop_mem_wdata;
          m_wstrb[d] = cop_mem_wen ? cop_mem_ben : 4'h0; m_instr[d] = 1'b0;
        end
      end
    end
    @(negedge g_clk);
  endtask

  task automatic idle_inputs();
    prv_mem_valid = 0; prv_mem_instr = 0; prv_mem_addr = 0; prv_mem_wdata = 0; prv_mem_wstrb = 0;
    cop_mem_cen = 0; cop_mem_wen = 0; cop_mem_addr = 0; cop_mem_wdata = 0; cop_mem_ben = 0;
    mem_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    g_resetn = 1'b0;
    model_reset();
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  task automatic quiesce();
    prv_mem_valid = 0; cop_mem_cen = 0; mem_ready = 1;
    step(); step();
    mem_ready = 0;
    step();
  endtask

  initial begin
    idle_inputs();
    mem_rdata = 32'hA5A5_A5A5;
    g_resetn  = 1'b0;
    model_reset();
    @(negedge g_clk);
    cop_mem_cen = 1;
    #1;
    chk(0, "rst_valid", o_valid[0], 0);
    chk(0, "rst_addr", o_addr[0], 0);
    chk(0, "rst_stall", o_stall[0], 0);
    chk(0, "rst_prv_ready", o_prv_ready[0], 0);
    chk(0, "rst_prv_rdata", o_prv_rdata[0], 32'hA5A5_A5A5);
    cop_mem_cen = 0;
    @(negedge g_clk);
    g_resetn = 1'b1;

    // PRV read alone
    prv_mem_valid = 1; prv_mem_addr = 32'hC000_0000; prv_mem_wstrb = 0; prv_mem_wdata = 32'h1111_2222;
    step();
    #1;
    chk(0, "prv_lat_valid", o_valid[0], 1);
    chk(0, "prv_rd_wstrb", o_wstrb[0], 0);
    step(); step();
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk(0, "prv_rd_ready", o_prv_ready[0], 1);
    chk(0, "prv_rd_rdata", o_prv_rdata[0], 32'hDEAD_BEEF);
    step();
    prv_mem_valid = 0; mem_ready = 0;
    step();

    // simultaneous first requests after reset
    do_reset();
    prv_mem_valid = 1; prv_mem_addr = 32'h100;
    cop_mem_cen = 1; cop_mem_addr = 32'h200; cop_mem_wen = 0;
    step();
    #1;
    chk(0, "tie_rr_first", o_addr[0], 32'h100);
    chk(1, "tie_fp_first", o_addr[1], 32'h200);
    chk(0, "tie_cop_stall", o_stall[0], 1);
    mem_ready = 1;
    step();
    prv_mem_valid = 0; mem_ready = 0;
    step();
    #1;
    chk(0, "tie_rr_second", o_addr[0], 32'h200);
    mem_ready = 1;
    step();
    cop_mem_cen = 0; mem_ready = 0;
    step();
    prv_mem_valid = 1; cop_mem_cen = 1;
    step();
    #1;
    chk(0, "tie_rr_third", o_addr[0], 32'h100);
    quiesce();

    // COP write then read
    cop_mem_cen = 1; cop_mem_wen = 1; cop_mem_ben = 4'h3; cop_mem_wdata = 32'h1234_5678; cop_mem_addr = 32'h300;
    step();
    #1;
    chk(0, "cop_wr_wstrb", o_wstrb[0], 4'h3);
    chk(0, "cop_wr_wdata", o_wdata[0], 32'h1234_5678);
    mem_ready = 1;
    step();
    cop_mem_wen = 0; cop_mem_ben = 4'hF; mem_ready = 0;
    step();
    #1;
    chk(0, "cop_rd_wstrb", o_wstrb[0], 4'h0);
    mem_ready = 1;
    step();
    quiesce();

    // COP timeout
    cop_mem_cen = 1; cop_mem_addr = 32'h400;
    step();
    for (int i = 1; i < TO; i++) step();
    #1;
    chk(0, "cop_to_error", o_cop_err[0], 1);
    chk(0, "cop_to_stall", o_stall[0], 0);
    step();
    cop_mem_cen = 0;
    #1;
    chk(0, "cop_to_valid", o_valid[0], 0);
    step();

    // PRV timeout
    prv_mem_valid = 1; prv_mem_addr = 32'h480; mem_rdata = 32'h5555_AAAA;
    step();
    for (int i = 1; i < TO; i++) step();
    #1;
    chk(0, "prv_to_error", o_prv_err[0], 1);
    chk(0, "prv_to_rdata", o_prv_rdata[0], 0);
    step();
    prv_mem_valid = 0;
    #1;
    chk(0, "prv_to_valid", o_valid[0], 0);
    step();

    // asynchronous reset mid GNT_COP
    cop_mem_cen = 1; cop_mem_addr = 32'h600;
    step(); step();
    g_resetn = 1'b0;
    #1;
    chk(0, "arst_valid", o_valid[0], 0);
    chk(0, "arst_stall", o_stall[0], 0);
    chk(0, "arst_cop_err", o_cop_err[0], 0);
    chk(0, "arst_prv_ready", o_prv_ready[0], 0);
    model_reset();
    @(posedge g_clk);
    @(negedge g_clk);
    prv_mem_valid = 1; prv_mem_addr = 32'h500;
    g_resetn = 1'b1;
    step();
    #1;
    chk(0, "arst_prv_pref", o_addr[0], 32'h500);
    quiesce();

    // fixed priority: COP keeps winning while it re-requests
    prv_mem_valid = 1; prv_mem_addr = 32'h700; cop_mem_cen = 1;
    for (int k = 0; k < 3; k++) begin
      cop_mem_addr = 32'h800 + 32'(k);
      step();
      #1;
      chk(1, "fp_cop_addr", o_addr[1], 32'h800 + 32'(k));
      mem_ready = 1;
      step();
      mem_ready = 0;
    end
    cop_mem_cen = 0;
    step();
    #1;
    chk(1, "fp_prv_addr", o_addr[1], 32'h700);
    quiesce();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (prv_mem_valid && prv_done_seen) prv_mem_valid = 0;
      else if (!prv_mem_valid && $urandom_range(2) == 0) begin
        prv_mem_valid = 1; prv_mem_addr = $urandom; prv_mem_wdata = $urandom;
        prv_mem_wstrb = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        prv_mem_instr = 1'($urandom_range(1));
      end
      if (cop_mem_cen && cop_done_seen) cop_mem_cen = 0;
      else if (!cop_mem_cen && $urandom_range(2) == 0) begin
        cop_mem_cen = 1; cop_mem_addr = $urandom; cop_mem_wdata = $urandom;
        cop_mem_wen = 1'($urandom_range(1)); cop_mem_ben = 4'($urandom);
      end
      mem_ready = ($urandom_range(3) == 0);
      mem_rdata = $urandom;
      step();
    end
    quiesce();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
